ex_muldiv_unit: RTL



---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_signfix.sv | 50 +++++
 rtl/ex_muldiv_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the EX-stage RV32M multiply/divide engine.
// Optional single-cycle multiplier: MULDIV_FAST_MUL_EN.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    localparam logic [6:0]  M_FUNCT7 = 7'b0000001;
    localparam logic [6:0]  OP_RTYPE = 7'b0110011;
    localparam logic [31:0] INT_MIN  = 32'h80000000;

endpackage

// File: rtl/muldiv_signfix.sv
// Operand magnitudes, result-sign flag and final 2's-complement fix-up.
// Purely combinational; shared by the multiply and divide paths.
module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]          funct3,
    input  logic [DATA_W-1:0]   op_a,
    input  logic [DATA_W-1:0]   op_b,
    output logic [DATA_W-1:0]   mag_a,
    output logic [DATA_W-1:0]   mag_b,
    output logic                neg,
    input  logic [2*DATA_W-1:0] fix_in,
    input  logic                fix_neg,
    output logic [2*DATA_W-1:0] fix_out
);

    logic sa;
    logic sb;

    always_comb begin
        sa  = 1'b0;
        sb  = 1'b0;
        neg = 1'b0;
        case (funct3)
            MUL, MULH, DIV: begin
                sa  = op_a[DATA_W-1];
                sb  = op_b[DATA_W-1];
                neg = sa ^ sb;
            end
            MULHSU: begin
                sa  = op_a[DATA_W-1];
                neg = sa;
            end
            // remainder follows the dividend sign only
            REM: begin
                sa  = op_a[DATA_W-1];
                sb  = op_b[DATA_W-1];
                neg = sa;
            end
            default: ;
        endcase
    end

    assign mag_a   = sa ? -op_a : op_a;
    assign mag_b   = sb ? -op_b : op_b;
    assign fix_out = fix_neg ? -fix_in : fix_in;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide engine sitting behind the ID/EX register.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier (divides stay iterative).
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              flush,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    muldiv_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic [DATA_W-1:0] res_q, res_d;

    logic [DATA_W-1:0]   mag_a, mag_b;
    logic                neg;
    logic [2*DATA_W-1:0] fix_in, fix_out;

    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   rsh;
    logic [DATA_W:0]   diff;
    logic              ge;
    logic [DATA_W-1:0] step_hi, step_lo;
    logic [DATA_W-1:0] final_res;
    logic              is_div, b_zero, ovf;

    muldiv_signfix #(.DATA_W(DATA_W)) u_signfix (
        .funct3  (funct3),
        .op_a    (op_a),
        .op_b    (op_b),
        .mag_a   (mag_a),
        .mag_b   (mag_b),
        .neg     (neg),
        .fix_in  (fix_in),
        .fix_neg (neg_q),
        .fix_out (fix_out)
    );

    // hi:lo is the product (mul) or remainder:quotient (div)
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
        rsh     = {hi_q, lo_q[DATA_W-1]};
        diff    = rsh - {1'b0, dvs_q};
        ge      = !diff[DATA_W];
        if (op_q[2]) begin
            step_hi = ge ? diff[DATA_W-1:0] : rsh[DATA_W-1:0];
            step_lo = {lo_q[DATA_W-2:0], ge};
            fix_in  = {{DATA_W{1'b0}}, op_q[1] ? step_hi : step_lo};
        end else begin
            step_hi = mul_sum[DATA_W:1];
            step_lo = {mul_sum[0], lo_q[DATA_W-1:1]};
            fix_in  = {step_hi, step_lo};
        end
        if (op_q[2] || op_q == MUL) final_res = fix_out[DATA_W-1:0];
        else                        final_res = fix_out[2*DATA_W-1:DATA_W];
    end

    assign is_div = funct3[2];
    assign b_zero = (op_b == '0);
    assign ovf    = is_div && !funct3[0] && (op_a == INT_MIN) && (op_b == '1);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [DATA_W:0] fa, fb;
    logic [2*DATA_W-1:0]    fprod;
    logic [DATA_W-1:0]      fres;

    always_comb begin
        fa    = {(funct3 != MULHU) & op_a[DATA_W-1], op_a};
        fb    = {(funct3 == MUL || funct3 == MULH) & op_b[DATA_W-1], op_b};
        fprod = (2*DATA_W)'(fa * fb);
        fres  = (funct3 == MUL) ? fprod[DATA_W-1:0] : fprod[2*DATA_W-1:DATA_W];
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dvs_d   = dvs_q;
        res_d   = res_q;
        case (state_q)
            IDLE: if (start) begin
                if (is_div && b_zero) begin
                    res_d   = funct3[1] ? op_a : '1;
                    state_d = DONE;
                end else if (ovf) begin
                    res_d   = funct3[1] ? '0 : INT_MIN;
                    state_d = DONE;
`ifdef MULDIV_FAST_MUL_EN
                end else if (!is_div) begin
                    res_d   = fres;
                    state_d = DONE;
`endif
                end else begin
                    op_d    = funct3;
                    neg_d   = neg;
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = is_div ? mag_a : mag_b;
                    dvs_d   = is_div ? mag_b : mag_a;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    res_d   = final_res;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dvs_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dvs_q   <= dvs_d;
            res_q   <= res_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE) && !flush;
    assign stall  = start && (state_q != DONE) && rst && !flush;
    assign result = res_q;

endmodule
